// File: rtl/mem2reg_bank_if.sv
// rtl/mem2reg_bank_if.sv - command, read-port and status bundle for mem2reg_bank
interface mem2reg_bank_if #(
    parameter int WIDTH = 4,
    parameter int AW    = 3
);
    logic [1:0]       op;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic             init_req;
    logic [AW-1:0]    raddr_a;
    logic [WIDTH-1:0] rdata_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_b;
    logic             busy;
    logic             init_done;
    logic             ovf;

    modport master (
        output op, addr, wdata, init_req, raddr_a, raddr_b,
        input  rdata_a, rdata_b, busy, init_done, ovf
    );

    modport slave (
        input  op, addr, wdata, init_req, raddr_a, raddr_b,
        output rdata_a, rdata_b, busy, init_done, ovf
    );
endinterface

// File: rtl/mem2reg_bank.sv
// rtl/mem2reg_bank.sv - flop-based DEPTH x WIDTH bank with write/clear/increment-all and sequenced re-init
module mem2reg_bank #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter bit SATURATE    = 1'b0,
    parameter int INIT_STRIDE = 1
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    mem2reg_bank_if.slave bus
);
    localparam logic [1:0]    OP_WRITE = 2'b01;
    localparam logic [1:0]    OP_INC   = 2'b10;
    localparam logic [1:0]    OP_CLEAR = 2'b11;
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic {IDLE, INIT} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH:0]   inc;

    // Truncation to WIDTH bits gives the mod 2**WIDTH of the pattern.
    function automatic logic [WIDTH-1:0] pattern(input int unsigned idx);
        int unsigned prod;
        prod = idx * INIT_STRIDE;
        return prod[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= pattern(unsigned'(i));
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        mem_d   = mem_q;
        inc     = '0;
        case (state_q)
            IDLE: begin
                if (bus.init_req) begin
                    // Accepting edge only arms the walk; the concurrent op is dropped.
                    state_d = INIT;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    case (bus.op)
                        OP_WRITE: begin
                            if ({1'b0, bus.addr} < DEPTH_W) mem_d[bus.addr] = bus.wdata;
                        end
                        OP_CLEAR: begin
                            if ({1'b0, bus.addr} < DEPTH_W) mem_d[bus.addr] = '0;
                        end
                        OP_INC: begin
                            for (int i = 0; i < DEPTH; i++) begin
                                inc = {1'b0, mem_q[i]} + (WIDTH+1)'(1);
                                if (inc[WIDTH]) begin
                                    ovf_d    = 1'b1;
                                    mem_d[i] = SATURATE ? mem_q[i] : inc[WIDTH-1:0];
                                end else begin
                                    mem_d[i] = inc[WIDTH-1:0];
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            INIT: begin
                mem_d[ptr_q] = pattern(unsigned'(int'(ptr_q)));
                ptr_d        = ptr_q + AW'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rdata_a   = ({1'b0, bus.raddr_a} < DEPTH_W) ? mem_q[bus.raddr_a] : '0;
    assign bus.rdata_b   = ({1'b0, bus.raddr_b} < DEPTH_W) ? mem_q[bus.raddr_b] : '0;
    assign bus.busy      = (state_q == INIT);
    assign bus.init_done = done_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_mem2reg_bank.sv
// tb/tb_mem2reg_bank.sv - directed bench: wrap, saturate and stride-3 banks driven in lockstep
`timescale 1ns/1ps
module tb_mem2reg_bank;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    mem2reg_bank_if #(.WIDTH(4), .AW(3)) if0 ();
    mem2reg_bank_if #(.WIDTH(4), .AW(3)) if1 ();
    mem2reg_bank_if #(.WIDTH(4), .AW(3)) if2 ();

    mem2reg_bank #(.WIDTH(4), .DEPTH(8), .AW(3), .SATURATE(1'b0), .INIT_STRIDE(1))
        dut_wrap (.clk_i(clk), .reset_ni(reset_n), .bus(if0.slave));
    mem2reg_bank #(.WIDTH(4), .DEPTH(8), .AW(3), .SATURATE(1'b1), .INIT_STRIDE(1))
        dut_sat (.clk_i(clk), .reset_ni(reset_n), .bus(if1.slave));
    mem2reg_bank #(.WIDTH(4), .DEPTH(8), .AW(3), .SATURATE(1'b0), .INIT_STRIDE(3))
        dut_s3 (.clk_i(clk), .reset_ni(reset_n), .bus(if2.slave));

    // The other two banks see exactly the stimulus of the first.
    assign if1.op = if0.op;       assign if2.op = if0.op;
    assign if1.addr = if0.addr;   assign if2.addr = if0.addr;
    assign if1.wdata = if0.wdata; assign if2.wdata = if0.wdata;
    assign if1.init_req = if0.init_req; assign if2.init_req = if0.init_req;
    assign if1.raddr_a = if0.raddr_a;   assign if2.raddr_a = if0.raddr_a;
    assign if1.raddr_b = if0.raddr_b;   assign if2.raddr_b = if0.raddr_b;

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bank(input int which, input string tag, input logic [3:0] exp [8]);
        for (int i = 0; i < 8; i++) begin
            if0.raddr_a = 3'(i);
            #1;
            case (which)
                0:       check_eq($sformatf("%s[%0d]", tag, i), 32'(if0.rdata_a), 32'(exp[i]));
                1:       check_eq($sformatf("%s[%0d]", tag, i), 32'(if1.rdata_a), 32'(exp[i]));
                default: check_eq($sformatf("%s[%0d]", tag, i), 32'(if2.rdata_a), 32'(exp[i]));
            endcase
        end
    endtask

    logic [3:0] pat1 [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [3:0] pat3 [8] = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2, 4'd5};
    logic [3:0] wrap9 [8] = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
    logic [3:0] sat9 [8]  = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15};
    logic [3:0] edit [8]  = '{4'd9, 4'd10, 4'd11, 4'd0, 4'd13, 4'd14, 4'd15, 4'd5};

    initial begin
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        if0.op = 2'b00; if0.addr = '0; if0.wdata = '0; if0.init_req = 1'b0;
        if0.raddr_a = '0; if0.raddr_b = '0;
        tick(); tick();
        reset_n = 1'b1;
        tick();

        check_bank(0, "reset_wrap", pat1);
        check_bank(2, "reset_s3", pat3);
        check_eq("reset_busy", 32'(if0.busy), 0);
        check_eq("reset_ovf", 32'(if0.ovf), 0);
        check_eq("reset_done", 32'(if0.init_done), 0);

        // Nine increments: entry7 first wraps on the ninth.
        if0.op = 2'b10;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 8) begin
                check_eq("ovf_before_wrap", 32'(if0.ovf), 0);
                check_eq("sat_ovf_before", 32'(if1.ovf), 0);
            end
        end
        if0.op = 2'b00;
        check_eq("ovf_after_wrap", 32'(if0.ovf), 1);
        check_eq("sat_ovf_after", 32'(if1.ovf), 1);
        check_bank(0, "inc9_wrap", wrap9);
        check_bank(1, "inc9_sat", sat9);

        if0.op = 2'b01; if0.addr = 3'd3; if0.wdata = 4'hA; if0.raddr_b = 3'd3;
        tick();
        check_eq("write_a_rdb", 32'(if0.rdata_b), 32'hA);
        if0.op = 2'b11;
        tick();
        check_eq("clear_rdb", 32'(if0.rdata_b), 0);
        if0.op = 2'b01; if0.addr = 3'd7; if0.wdata = 4'd5;
        tick();
        if0.op = 2'b00;
        check_bank(0, "write7", edit);

        // Init request with a simultaneous write to entry0: the write must be lost.
        if0.op = 2'b01; if0.addr = 3'd0; if0.wdata = 4'hF; if0.init_req = 1'b1;
        tick();
        if0.op = 2'b00; if0.init_req = 1'b0;
        if0.raddr_a = 3'd0;
        #1;
        check_eq("accept_entry0", 32'(if0.rdata_a), 9);
        check_eq("accept_ovf_clr", 32'(if0.ovf), 0);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("walk_busy%0d", k), 32'(if0.busy), 1);
            check_eq($sformatf("walk_nodone%0d", k), 32'(if0.init_done), 0);
            if (k == 2 || k == 3) begin
                if0.op = 2'b01; if0.addr = 3'd0; if0.wdata = 4'hF; if0.init_req = 1'b1;
            end else begin
                if0.op = 2'b00; if0.init_req = 1'b0;
            end
            tick();
            if0.raddr_a = 3'(k);
            #1;
            check_eq($sformatf("walk_entry%0d", k), 32'(if0.rdata_a), k);
            if (k < 7) begin
                if0.raddr_a = 3'(k + 1);
                #1;
                check_eq($sformatf("walk_old%0d", k + 1), 32'(if0.rdata_a), 32'(edit[k + 1]));
            end
        end
        if0.op = 2'b00; if0.init_req = 1'b0;
        check_eq("walk_end_busy", 32'(if0.busy), 0);
        check_eq("walk_done", 32'(if0.init_done), 1);
        check_eq("walk_ovf", 32'(if0.ovf), 0);
        check_bank(0, "after_init", pat1);
        check_bank(2, "after_init_s3", pat3);
        tick();
        check_eq("done_one_cycle", 32'(if0.init_done), 0);
        check_eq("no_queued_init", 32'(if0.busy), 0);

        // Scramble, start a walk, then reset it after four written entries.
        if0.op = 2'b01; if0.addr = 3'd2; if0.wdata = 4'hC;
        tick();
        if0.op = 2'b10;
        tick();
        if0.op = 2'b00; if0.init_req = 1'b1;
        tick();
        if0.init_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check_eq("midwalk_busy", 32'(if0.busy), 1);
        if0.raddr_a = 3'd5;
        #1;
        check_eq("midwalk_old5", 32'(if0.rdata_a), 6);
        reset_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'(if0.busy), 0);
        check_eq("rst_done", 32'(if0.init_done), 0);
        check_bank(0, "rst_midwalk", pat1);
        check_bank(2, "rst_midwalk_s3", pat3);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq($sformatf("post_rst_nodone%0d", k), 32'(if0.init_done), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem2reg_bank.md
Name: mem2reg_bank

Overview:
- Parametrised register-bank memory (DEPTH x WIDTH).
- The whole array is flattened to flops; no RAM inference.
- Supports async pattern-initialise, single-entry write, single-entry clear, and a bulk increment-all mode with wrap or saturate.
- Adds a sequenced re-initialise engine with a busy/done handshake, two combinational read ports, and a sticky overflow flag.
- Serves as the generalised successor of the team's small mem2reg test blocks, and as a reusable counter/lookup bank.

Parameters:
- WIDTH, 4: bits per entry.
- DEPTH, 8: number of entries (2..2**AW).
- AW, 3: address width.
- SATURATE, 0: increment overflow policy. 0 = wrap to 0; 1 = hold at all-ones.
- INIT_STRIDE, 1: init pattern is entry[i] = (i*INIT_STRIDE) mod 2**WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- op  in  2  command. 00 = hold, 01 = write addr with wdata, 10 = increment all, 11 = clear addr.
- addr  in  AW  target address for op 01/11.
- wdata  in  WIDTH  write data for op 01.
- init_req  in  1  request a sequenced re-initialise.
- raddr_a  in  AW  read address, port A.
- rdata_a  out  WIDTH  entry[raddr_a], combinational.
- raddr_b  in  AW  read address, port B.
- rdata_b  out  WIDTH  entry[raddr_b], combinational.
- busy  out  1  high while the init engine is walking.
- init_done  out  1  one-cycle pulse when the walk completes.
- ovf  out  1  sticky flag: some increment overflowed.

Behaviour:
- Reset low (async, overrides everything):
  - entry[i] = (i*INIT_STRIDE) mod 2**WIDTH.
  - FSM = IDLE, ptr = 0, busy = 0, init_done = 0, ovf = 0.
- Read ports:
  - Purely combinational from the current flop state. A write at edge N is visible after edge N.
  - raddr >= DEPTH returns 0.
- FSM states IDLE and INIT.
- IDLE, init_req = 1 at an edge:
  - Go to INIT with ptr = 0 and clear ovf.
  - op in that same cycle is dropped; init wins.
  - No entry is written on the accepting edge.
- IDLE, init_req = 0: op executes at the edge.
  - 01: entry[addr] <= wdata.
  - 11: entry[addr] <= 0.
  - 10: every entry <= entry + 1, in WIDTH bits.
    - An entry at all-ones goes to 0 (SATURATE=0) or stays all-ones (SATURATE=1).
    - In either case ovf <= 1.
  - 01/11 with addr >= DEPTH: no effect.
  - 00: no change.
- INIT state:
  - Each edge writes entry[ptr] <= (ptr*INIT_STRIDE) mod 2**WIDTH and increments ptr.
  - On the edge writing ptr = DEPTH-1: return to IDLE and set init_done = 1 for exactly one cycle.
  - busy = 1 for exactly DEPTH cycles (the cycle after acceptance through the cycle of the last write). busy is registered, i.e. equal to (state == INIT).
  - op and init_req are ignored while busy. Requests are not queued.
  - Entries not yet walked keep their old values and remain readable.
- init_done is asserted in the first IDLE cycle after the walk. A new init_req is accepted in that same cycle.
- ovf stays 1 until reset or an accepted init_req.
- Reset asserted mid-walk: immediate full pattern load, FSM to IDLE, no init_done pulse.
- All arithmetic is unsigned. The increment carry-out is used only for ovf and saturation.

Test Plan:
- Defaults. Release reset, read all 8 addresses via port A -> 0,1,…,7. busy = 0, ovf = 0.
- op = 10 for 9 consecutive cycles:
  - SATURATE=0 -> entry7 wraps to 0 after the 9th increment. Final values: 9 mod 16 = 9, 10, …, 15, then entry7 = 0. ovf = 1 from the edge of the first wrap.
  - SATURATE=1 -> entry7 holds 15, entry6 reaches 15, ovf = 1.
- Write then clear:
  - op = 01, addr = 3, wdata = 0xA -> rdata_b(raddr_b = 3) = 0xA on the next cycle.
  - op = 11, addr = 3 -> 0.
  - op = 01, addr = 7, wdata = 5 -> entry7 = 5, other entries unchanged.
- Sequenced init after scrambling the entries:
  - Pulse init_req with op = 01 in the same cycle -> the write is dropped.
  - busy is high for exactly 8 cycles and entries are restored in index order.
  - init_done pulses for one cycle, ovf is cleared.
  - op and init_req issued during busy have no effect.
- Reset mid-walk: assert reset at walk cycle 4 -> all entries immediately take the pattern, busy = 0, no init_done pulse.
- INIT_STRIDE = 3, WIDTH = 4: entries after reset/init -> 0,3,6,9,12,15,2,5.
